// File: rtl/soc_glip_dii_bridge_if.sv
// -----------------------------------------------------------------------------
// soc_glip_dii_bridge_if
// Groups the four streaming channels of the GLIP <-> DII bridge and its two
// error pulses into one bundle.
//   glip_in_*  : host-to-target 16-bit words  (valid/ready)
//   dii_out_*  : flits towards the debug ring (data/last/valid/ready)
//   dii_in_*   : flits from the debug ring    (data/last/valid/ready)
//   glip_out_* : target-to-host 16-bit words  (valid/ready)
//   err_*      : single-cycle error pulses from the bridge
// Modport slave is the bridge itself; modport master is its environment.
// -----------------------------------------------------------------------------
interface soc_glip_dii_bridge_if;
   logic [15:0] glip_in_data;
   logic        glip_in_valid;
   logic        glip_in_ready;

   logic [15:0] dii_out_data;
   logic        dii_out_last;
   logic        dii_out_valid;
   logic        dii_out_ready;

   logic [15:0] dii_in_data;
   logic        dii_in_last;
   logic        dii_in_valid;
   logic        dii_in_ready;

   logic [15:0] glip_out_data;
   logic        glip_out_valid;
   logic        glip_out_ready;

   logic        err_ingress;
   logic        err_egress;

   modport slave (
      input  glip_in_data, glip_in_valid,
      output glip_in_ready,
      output dii_out_data, dii_out_last, dii_out_valid,
      input  dii_out_ready,
      input  dii_in_data, dii_in_last, dii_in_valid,
      output dii_in_ready,
      output glip_out_data, glip_out_valid,
      input  glip_out_ready,
      output err_ingress, err_egress
   );

   modport master (
      output glip_in_data, glip_in_valid,
      input  glip_in_ready,
      input  dii_out_data, dii_out_last, dii_out_valid,
      output dii_out_ready,
      output dii_in_data, dii_in_last, dii_in_valid,
      input  dii_in_ready,
      input  glip_out_data, glip_out_valid,
      output glip_out_ready,
      input  err_ingress, err_egress
   );
endinterface

// File: rtl/soc_glip_dii_bridge.sv
// -----------------------------------------------------------------------------
// soc_glip_dii_bridge
// Host-side bridge between the 16-bit GLIP word channel and the DII flit ring.
//   Ingress: a GLIP length word followed by that many payload words is turned
//            into a DII packet with a generated last flag (zero-latency
//            pass-through). Zero-length headers are skipped; oversize headers
//            make the payload get swallowed and pulse err_ingress.
//   Egress:  a DII packet is collected into a MAX_PKT_LEN-deep buffer, then
//            sent to GLIP as a length word followed by the buffered words.
//            Flits beyond MAX_PKT_LEN are dropped and pulse err_egress once.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - channel bundle (slave side), see soc_glip_dii_bridge_if
// -----------------------------------------------------------------------------
module soc_glip_dii_bridge #(
   parameter int MAX_PKT_LEN = 12,
   parameter int CNT_W       = $clog2(MAX_PKT_LEN + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   soc_glip_dii_bridge_if.slave        bus
);

   localparam logic [15:0]      MAX_LEN16 = 16'(MAX_PKT_LEN);
   localparam logic [CNT_W-1:0] MAX_LEN   = CNT_W'(MAX_PKT_LEN);

   // ---------------------------------------------------------------------------
   // Ingress: GLIP words -> DII flits
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {I_HDR, I_PAY, I_DROP} i_state_t;

   i_state_t    i_state, i_state_nxt;
   // Full 16-bit remaining count: an oversize header must swallow exactly the
   // number of words it announced, which can exceed the CNT_W range.
   logic [15:0] rem, rem_nxt;
   logic        err_in_set;
   logic        err_in_q;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_state  <= I_HDR;
         rem      <= '0;
         err_in_q <= 1'b0;
      end else begin
         i_state  <= i_state_nxt;
         rem      <= rem_nxt;
         err_in_q <= err_in_set;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      i_state_nxt       = i_state;
      rem_nxt           = rem;
      err_in_set        = 1'b0;
      bus.glip_in_ready = 1'b0;
      bus.dii_out_valid = 1'b0;
      bus.dii_out_data  = '0;
      bus.dii_out_last  = 1'b0;

      unique case (i_state)
         I_HDR: begin
            bus.glip_in_ready = 1'b1;
            // A zero header is consumed without leaving I_HDR.
            if (bus.glip_in_valid && (bus.glip_in_data != 16'd0)) begin
               rem_nxt = bus.glip_in_data;
               if (bus.glip_in_data > MAX_LEN16) begin
                  err_in_set  = 1'b1;
                  i_state_nxt = I_DROP;
               end else begin
                  i_state_nxt = I_PAY;
               end
            end
         end

         I_PAY: begin
            // Pure combinational pass-through; the ring's ready throttles GLIP.
            bus.dii_out_valid = bus.glip_in_valid;
            bus.dii_out_data  = bus.glip_in_data;
            bus.dii_out_last  = (rem == 16'd1);
            bus.glip_in_ready = bus.dii_out_ready;
            if (bus.glip_in_valid && bus.dii_out_ready) begin
               rem_nxt = rem - 16'd1;
               if (rem == 16'd1) i_state_nxt = I_HDR;
            end
         end

         I_DROP: begin
            bus.glip_in_ready = 1'b1;
            if (bus.glip_in_valid) begin
               rem_nxt = rem - 16'd1;
               if (rem == 16'd1) i_state_nxt = I_HDR;
            end
         end

         default: i_state_nxt = I_HDR;
      endcase
   end

   assign bus.err_ingress = err_in_q;

   // ---------------------------------------------------------------------------
   // Egress: DII packet -> buffer -> GLIP length word + payload
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {E_COLLECT, E_HDR, E_DATA} e_state_t;

   e_state_t         e_state, e_state_nxt;
   logic [15:0]      buf_mem [MAX_PKT_LEN];
   // wcnt doubles as the packet length n once collection has finished.
   logic [CNT_W-1:0] wcnt, wcnt_nxt;
   logic [CNT_W-1:0] rcnt, rcnt_nxt;
   // Set once the current packet has overflowed, so err_egress fires only once.
   logic             ovf, ovf_nxt;
   logic             buf_we;
   logic             err_eg_set;
   logic             err_eg_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_state  <= E_COLLECT;
         wcnt     <= '0;
         rcnt     <= '0;
         ovf      <= 1'b0;
         err_eg_q <= 1'b0;
      end else begin
         e_state  <= e_state_nxt;
         wcnt     <= wcnt_nxt;
         rcnt     <= rcnt_nxt;
         ovf      <= ovf_nxt;
         err_eg_q <= err_eg_set;
      end
   end

   // NOTE: the packet buffer has no reset; it is always written before it is
   // read, so clearing it would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (buf_we) buf_mem[wcnt] <= bus.dii_in_data;
   end

   always_comb begin
      e_state_nxt        = e_state;
      wcnt_nxt           = wcnt;
      rcnt_nxt           = rcnt;
      ovf_nxt            = ovf;
      buf_we             = 1'b0;
      err_eg_set         = 1'b0;
      bus.dii_in_ready   = 1'b0;
      bus.glip_out_valid = 1'b0;
      bus.glip_out_data  = '0;

      unique case (e_state)
         E_COLLECT: begin
            bus.dii_in_ready = 1'b1;
            if (bus.dii_in_valid) begin
               if (wcnt < MAX_LEN) begin
                  buf_we   = 1'b1;
                  wcnt_nxt = wcnt + CNT_W'(1);
               end else if (!ovf) begin
                  ovf_nxt    = 1'b1;
                  err_eg_set = 1'b1;
               end
               if (bus.dii_in_last) e_state_nxt = E_HDR;
            end
         end

         E_HDR: begin
            bus.glip_out_valid = 1'b1;
            bus.glip_out_data  = 16'(wcnt);
            if (bus.glip_out_ready) begin
               rcnt_nxt    = '0;
               e_state_nxt = E_DATA;
            end
         end

         E_DATA: begin
            bus.glip_out_valid = 1'b1;
            bus.glip_out_data  = buf_mem[rcnt];
            if (bus.glip_out_ready) begin
               if (rcnt == wcnt - CNT_W'(1)) begin
                  wcnt_nxt    = '0;
                  ovf_nxt     = 1'b0;
                  e_state_nxt = E_COLLECT;
               end else begin
                  rcnt_nxt = rcnt + CNT_W'(1);
               end
            end
         end

         default: e_state_nxt = E_COLLECT;
      endcase
   end

   assign bus.err_egress = err_eg_q;

endmodule

// File: tb/tb_soc_glip_dii_bridge.sv
// -----------------------------------------------------------------------------
// tb_soc_glip_dii_bridge
// Self-checking bench for soc_glip_dii_bridge. Inputs are driven 1 time unit
// after the rising edge; a monitor samples on the falling edge and records
// every completed transfer, which the scenario tasks compare against constants
// or a packet-level reference model.
// -----------------------------------------------------------------------------
module tb_soc_glip_dii_bridge;

   localparam int MAX = 12;

   typedef struct {
      logic [15:0] data;
      logic        last;
   } flit_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   soc_glip_dii_bridge_if bus();

   soc_glip_dii_bridge #(.MAX_PKT_LEN(MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // 0: both readies high, 1: toggle every cycle, 2: random, 3: manual
   int rdy_mode = 3;

   flit_t       got_flits[$];
   logic [15:0] got_glip[$];
   int          got_err_in, got_err_eg, pt_viol, rdy_viol;

   flit_t       exp_flits[$];
   logic [15:0] exp_glip[$];
   int          exp_err_in, exp_err_eg;

   flit_t       mon_f;

   // Watchdog: the run must always end on its own.
   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   // Sink ready generation.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: begin
            bus.dii_out_ready  = 1'b1;
            bus.glip_out_ready = 1'b1;
         end
         1: begin
            bus.dii_out_ready  = ~bus.dii_out_ready;
            bus.glip_out_ready = ~bus.glip_out_ready;
         end
         2: begin
            bus.dii_out_ready  = (($urandom % 4) != 0);
            bus.glip_out_ready = (($urandom % 4) != 0);
         end
         default: ;
      endcase
   end

   // Transfer monitor and protocol observers.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.dii_out_valid && bus.dii_out_ready) begin
            mon_f.data = bus.dii_out_data;
            mon_f.last = bus.dii_out_last;
            got_flits.push_back(mon_f);
         end
         // While a flit is offered the bridge is in pass-through.
         if (bus.dii_out_valid &&
             ((bus.glip_in_ready !== bus.dii_out_ready) || (bus.dii_out_data !== bus.glip_in_data)))
            pt_viol++;
         if (bus.glip_out_valid && bus.glip_out_ready) got_glip.push_back(bus.glip_out_data);
         // The egress side never collects while it is emitting.
         if (bus.glip_out_valid && bus.dii_in_ready) rdy_viol++;
         if (bus.err_ingress) got_err_in++;
         if (bus.err_egress)  got_err_eg++;
      end
   end

   // ---------------------------------------------------------------------------
   // Helpers (stimulus, bookkeeping and reference model only)
   // ---------------------------------------------------------------------------
   task automatic clear_obs();
      got_flits.delete();
      got_glip.delete();
      exp_flits.delete();
      exp_glip.delete();
      got_err_in = 0; got_err_eg = 0; pt_viol = 0; rdy_viol = 0;
      exp_err_in = 0; exp_err_eg = 0;
   endtask

   task automatic send_glip(input logic [15:0] w[$], input int max_gap);
      int t;
      foreach (w[i]) begin
         repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk); #1;
            bus.glip_in_valid = 1'b0;
         end
         @(posedge clk); #1;
         bus.glip_in_valid = 1'b1;
         bus.glip_in_data  = w[i];
         t = 0;
         @(negedge clk);
         while (!bus.glip_in_ready && t < 500) begin
            t++;
            @(negedge clk);
         end
         if (t >= 500) begin
            checks++; errors++;
            $display("FAIL glip_in_timeout word %0d value=%h never accepted", i, w[i]);
            bus.glip_in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      bus.glip_in_valid = 1'b0;
   endtask

   task automatic send_dii(input flit_t fl[$], input int max_gap);
      int t;
      foreach (fl[i]) begin
         repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk); #1;
            bus.dii_in_valid = 1'b0;
         end
         @(posedge clk); #1;
         bus.dii_in_valid = 1'b1;
         bus.dii_in_data  = fl[i].data;
         bus.dii_in_last  = fl[i].last;
         t = 0;
         @(negedge clk);
         while (!bus.dii_in_ready && t < 500) begin
            t++;
            @(negedge clk);
         end
         if (t >= 500) begin
            checks++; errors++;
            $display("FAIL dii_in_timeout flit %0d value=%h never accepted", i, fl[i].data);
            bus.dii_in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      bus.dii_in_valid = 1'b0;
      bus.dii_in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((got_flits.size() < exp_flits.size() || got_glip.size() < exp_glip.size()) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         checks++; errors++;
         $display("FAIL drain_timeout flits got=%0d need=%0d glip got=%0d need=%0d",
                  got_flits.size(), exp_flits.size(), got_glip.size(), exp_glip.size());
      end
      repeat (6) @(negedge clk);
   endtask

   // Ingress model: walk the word stream header by header.
   task automatic model_ingress(input logic [15:0] w[$]);
      int    i;
      int    len;
      flit_t f;
      i = 0;
      while (i < w.size()) begin
         len = int'(w[i]);
         i++;
         if (len > MAX) begin
            exp_err_in++;
            i += len;
         end else begin
            for (int k = 0; k < len; k++) begin
               f.data = w[i];
               f.last = (k == len - 1);
               exp_flits.push_back(f);
               i++;
            end
         end
      end
   endtask

   // Egress model: each packet becomes min(len,MAX) followed by its first words.
   task automatic model_egress(input flit_t fl[$]);
      logic [15:0] pkt[$];
      int          n;
      foreach (fl[j]) begin
         pkt.push_back(fl[j].data);
         if (fl[j].last) begin
            n = (pkt.size() > MAX) ? MAX : pkt.size();
            exp_glip.push_back(16'(n));
            for (int k = 0; k < n; k++) exp_glip.push_back(pkt[k]);
            if (pkt.size() > MAX) exp_err_eg++;
            pkt.delete();
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [38:0] obs;
      logic [38:0] exp_v;
      exp_v = {1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
      repeat (3) @(negedge clk);
      obs = {bus.glip_in_ready, bus.dii_out_valid, bus.dii_out_last, bus.dii_out_data,
             bus.dii_in_ready, bus.glip_out_valid, bus.glip_out_data, bus.err_ingress, bus.err_egress};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_in_reset got=%h exp=%h", obs, exp_v);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      obs = {bus.glip_in_ready, bus.dii_out_valid, bus.dii_out_last, bus.dii_out_data,
             bus.dii_in_ready, bus.glip_out_valid, bus.glip_out_data, bus.err_ingress, bus.err_egress};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_after_release got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_ingress_basic();
      logic [15:0] w[$];
      flit_t       f;
      clear_obs();
      rdy_mode = 0;
      w = {16'h0003, 16'hA001, 16'hA002, 16'hA003};
      f.data = 16'hA001; f.last = 1'b0; exp_flits.push_back(f);
      f.data = 16'hA002; f.last = 1'b0; exp_flits.push_back(f);
      f.data = 16'hA003; f.last = 1'b1; exp_flits.push_back(f);
      send_glip(w, 0);
      wait_drain();
      checks++;
      if (got_flits.size() !== 3) begin
         errors++;
         $display("FAIL ing_basic_count got=%0d exp=3", got_flits.size());
      end
      foreach (exp_flits[i]) if (i < got_flits.size()) begin
         checks++;
         if (got_flits[i].data !== exp_flits[i].data || got_flits[i].last !== exp_flits[i].last) begin
            errors++;
            $display("FAIL ing_basic_flit[%0d] got=%h/%b exp=%h/%b", i,
                     got_flits[i].data, got_flits[i].last, exp_flits[i].data, exp_flits[i].last);
         end
      end
      // Back in the header state: ready stays high even with the ring stalled.
      rdy_mode = 3;
      @(posedge clk); #1;
      bus.dii_out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.glip_in_ready !== 1'b1 || bus.dii_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ing_basic_idle glip_in_ready=%b dii_out_valid=%b exp 1/0",
                  bus.glip_in_ready, bus.dii_out_valid);
      end
   endtask

   task automatic test_ingress_backpressure();
      logic [15:0] w[$];
      flit_t       f;
      clear_obs();
      rdy_mode = 1;
      w = {16'h0000, 16'h0002, 16'hB001, 16'hB002};
      f.data = 16'hB001; f.last = 1'b0; exp_flits.push_back(f);
      f.data = 16'hB002; f.last = 1'b1; exp_flits.push_back(f);
      send_glip(w, 0);
      wait_drain();
      checks++;
      if (got_flits.size() !== 2) begin
         errors++;
         $display("FAIL ing_bp_count got=%0d exp=2", got_flits.size());
      end
      foreach (exp_flits[i]) if (i < got_flits.size()) begin
         checks++;
         if (got_flits[i].data !== exp_flits[i].data || got_flits[i].last !== exp_flits[i].last) begin
            errors++;
            $display("FAIL ing_bp_flit[%0d] got=%h/%b exp=%h/%b", i,
                     got_flits[i].data, got_flits[i].last, exp_flits[i].data, exp_flits[i].last);
         end
      end
      checks++;
      if (pt_viol !== 0) begin
         errors++;
         $display("FAIL ing_bp_passthrough cycles_bad=%0d exp=0", pt_viol);
      end
      checks++;
      if (got_err_in !== 0) begin
         errors++;
         $display("FAIL ing_bp_err_ingress pulses=%0d exp=0", got_err_in);
      end
   endtask

   task automatic test_ingress_oversize();
      logic [15:0] w[$];
      clear_obs();
      rdy_mode = 0;
      w.push_back(16'h000D);
      for (int i = 0; i < 13; i++) w.push_back(16'hD000 + 16'(i));
      w.push_back(16'h0001);
      w.push_back(16'hC0DE);
      exp_flits.push_back('{16'hC0DE, 1'b1});
      send_glip(w, 1);
      wait_drain();
      checks++;
      if (got_err_in !== 1) begin
         errors++;
         $display("FAIL ing_over_err_pulses got=%0d exp=1", got_err_in);
      end
      checks++;
      if (got_flits.size() !== 1) begin
         errors++;
         $display("FAIL ing_over_count got=%0d exp=1", got_flits.size());
      end else begin
         checks++;
         if (got_flits[0].data !== 16'hC0DE || got_flits[0].last !== 1'b1) begin
            errors++;
            $display("FAIL ing_over_flit got=%h/%b exp=c0de/1", got_flits[0].data, got_flits[0].last);
         end
      end
   endtask

   task automatic test_egress_basic();
      flit_t fl[$];
      flit_t f;
      clear_obs();
      rdy_mode = 0;
      f.data = 16'h1111; f.last = 1'b0; fl.push_back(f);
      f.data = 16'h2222; f.last = 1'b1; fl.push_back(f);
      exp_glip = {16'h0002, 16'h1111, 16'h2222};
      send_dii(fl, 0);
      // One edge after the last-flit transfer the header must be on offer.
      checks++;
      if (bus.glip_out_valid !== 1'b1 || bus.glip_out_data !== 16'h0002 || bus.dii_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL eg_basic_hdr_latency valid=%b data=%h dii_in_ready=%b exp 1/0002/0",
                  bus.glip_out_valid, bus.glip_out_data, bus.dii_in_ready);
      end
      wait_drain();
      checks++;
      if (got_glip.size() !== 3) begin
         errors++;
         $display("FAIL eg_basic_count got=%0d exp=3", got_glip.size());
      end
      foreach (exp_glip[i]) if (i < got_glip.size()) begin
         checks++;
         if (got_glip[i] !== exp_glip[i]) begin
            errors++;
            $display("FAIL eg_basic_word[%0d] got=%h exp=%h", i, got_glip[i], exp_glip[i]);
         end
      end
      checks++;
      if (rdy_viol !== 0 || bus.dii_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL eg_basic_ready overlap_cycles=%0d dii_in_ready=%b exp 0/1",
                  rdy_viol, bus.dii_in_ready);
      end
   endtask

   task automatic test_egress_overflow();
      flit_t fl[$];
      flit_t f;
      clear_obs();
      rdy_mode = 0;
      for (int i = 0; i < 14; i++) begin
         f.data = 16'h3000 + 16'(i);
         f.last = (i == 13);
         fl.push_back(f);
      end
      exp_glip.push_back(16'h000C);
      for (int i = 0; i < 12; i++) exp_glip.push_back(16'h3000 + 16'(i));
      send_dii(fl, 0);
      wait_drain();
      checks++;
      if (got_err_eg !== 1) begin
         errors++;
         $display("FAIL eg_ovf_err_pulses got=%0d exp=1", got_err_eg);
      end
      checks++;
      if (got_glip.size() !== 13) begin
         errors++;
         $display("FAIL eg_ovf_count got=%0d exp=13", got_glip.size());
      end
      foreach (exp_glip[i]) if (i < got_glip.size()) begin
         checks++;
         if (got_glip[i] !== exp_glip[i]) begin
            errors++;
            $display("FAIL eg_ovf_word[%0d] got=%h exp=%h", i, got_glip[i], exp_glip[i]);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] w[$];
      flit_t       fl[$];
      flit_t       f;
      logic [38:0] obs;
      logic [38:0] exp_v;
      exp_v = {1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
      clear_obs();
      rdy_mode = 3;
      @(posedge clk); #1;
      bus.dii_out_ready  = 1'b1;
      bus.glip_out_ready = 1'b0;
      // Header 3 plus one payload word leaves two words outstanding.
      w = {16'h0003, 16'h4441};
      send_glip(w, 0);
      f.data = 16'h7771; f.last = 1'b0; fl.push_back(f);
      f.data = 16'h7772; f.last = 1'b0; fl.push_back(f);
      f.data = 16'h7773; f.last = 1'b1; fl.push_back(f);
      send_dii(fl, 0);
      // Let the header and the first data word go out.
      bus.glip_out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      bus.glip_out_ready = 1'b0;
      bus.glip_in_valid  = 1'b1;
      bus.glip_in_data   = 16'h4442;
      #1;
      checks++;
      if (bus.dii_out_valid !== 1'b1 || bus.dii_out_last !== 1'b0 ||
          bus.glip_out_valid !== 1'b1 || bus.glip_out_data !== 16'h7772) begin
         errors++;
         $display("FAIL rst_mid_setup dii_out_valid=%b last=%b glip_out_valid=%b data=%h exp 1/0/1/7772",
                  bus.dii_out_valid, bus.dii_out_last, bus.glip_out_valid, bus.glip_out_data);
      end
      #1;
      rst = 1'b1;
      #1;
      obs = {bus.glip_in_ready, bus.dii_out_valid, bus.dii_out_last, bus.dii_out_data,
             bus.dii_in_ready, bus.glip_out_valid, bus.glip_out_data, bus.err_ingress, bus.err_egress};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL rst_mid_outputs got=%h exp=%h", obs, exp_v);
      end
      bus.glip_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
      rdy_mode = 0;
      w = {16'h0001, 16'h5555};
      exp_flits.push_back('{16'h5555, 1'b1});
      send_glip(w, 0);
      wait_drain();
      checks++;
      if (got_flits.size() !== 1) begin
         errors++;
         $display("FAIL rst_mid_after_count got=%0d exp=1", got_flits.size());
      end else begin
         checks++;
         if (got_flits[0].data !== 16'h5555 || got_flits[0].last !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after_flit got=%h/%b exp=5555/1", got_flits[0].data, got_flits[0].last);
         end
      end
      checks++;
      if (got_glip.size() !== 0) begin
         errors++;
         $display("FAIL rst_mid_egress_discard glip_words=%0d exp=0", got_glip.size());
      end
   endtask

   task automatic test_random();
      logic [15:0] w[$];
      flit_t       fl[$];
      flit_t       f;
      int          len;
      clear_obs();
      rdy_mode = 2;
      for (int p = 0; p < 14; p++) begin
         len = $urandom_range(MAX + 3, 0);
         w.push_back(16'(len));
         for (int k = 0; k < len; k++) w.push_back(16'($urandom));
      end
      for (int p = 0; p < 10; p++) begin
         len = $urandom_range(MAX + 3, 1);
         for (int k = 0; k < len; k++) begin
            f.data = 16'($urandom);
            f.last = (k == len - 1);
            fl.push_back(f);
         end
      end
      model_ingress(w);
      model_egress(fl);
      fork
         send_glip(w, 2);
         send_dii(fl, 2);
      join
      wait_drain();
      checks++;
      if (got_flits.size() !== exp_flits.size()) begin
         errors++;
         $display("FAIL rnd_flit_count got=%0d exp=%0d", got_flits.size(), exp_flits.size());
      end
      foreach (exp_flits[i]) if (i < got_flits.size()) begin
         checks++;
         if (got_flits[i].data !== exp_flits[i].data || got_flits[i].last !== exp_flits[i].last) begin
            errors++;
            $display("FAIL rnd_flit[%0d] got=%h/%b exp=%h/%b", i,
                     got_flits[i].data, got_flits[i].last, exp_flits[i].data, exp_flits[i].last);
         end
      end
      checks++;
      if (got_glip.size() !== exp_glip.size()) begin
         errors++;
         $display("FAIL rnd_glip_count got=%0d exp=%0d", got_glip.size(), exp_glip.size());
      end
      foreach (exp_glip[i]) if (i < got_glip.size()) begin
         checks++;
         if (got_glip[i] !== exp_glip[i]) begin
            errors++;
            $display("FAIL rnd_glip[%0d] got=%h exp=%h", i, got_glip[i], exp_glip[i]);
         end
      end
      checks++;
      if (got_err_in !== exp_err_in || got_err_eg !== exp_err_eg) begin
         errors++;
         $display("FAIL rnd_err_pulses ingress=%0d/%0d egress=%0d/%0d (got/exp)",
                  got_err_in, exp_err_in, got_err_eg, exp_err_eg);
      end
      checks++;
      if (pt_viol !== 0 || rdy_viol !== 0) begin
         errors++;
         $display("FAIL rnd_protocol passthrough_bad=%0d overlap_bad=%0d exp 0/0", pt_viol, rdy_viol);
      end
   endtask

   initial begin
      rst                = 1'b1;
      bus.glip_in_data   = '0;
      bus.glip_in_valid  = 1'b0;
      bus.dii_out_ready  = 1'b0;
      bus.dii_in_data    = '0;
      bus.dii_in_last    = 1'b0;
      bus.dii_in_valid   = 1'b0;
      bus.glip_out_ready = 1'b0;
      clear_obs();

      test_reset();
      test_ingress_basic();
      test_ingress_backpressure();
      test_ingress_oversize();
      test_egress_basic();
      test_egress_overflow();
      test_reset_mid_op();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/soc_glip_dii_bridge.md
Name: soc_glip_dii_bridge

Overview:
- Host-side bridge between the 16-bit GLIP word channel and the debug interconnect (DII) flit stream of the 2D RISC-V MPSoC.
- Ingress: length-prefixed GLIP words become DII flits with a generated `last`.
- Egress: DII packets are buffered, then sent to GLIP as a length word followed by the payload.
- Sits directly between the `c_glip_in`/`c_glip_out` channels of the system top and the debug ring.

Parameters:
- MAX_PKT_LEN, 12, maximum DII packet length in 16-bit words; equals CONFIG.DEBUG_MAX_PKT_LEN.
- CNT_W, $clog2(MAX_PKT_LEN+1), width of length and index counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- glip_in_data  in  16  host-to-target word
- glip_in_valid  in  1  word valid
- glip_in_ready  out  1  word accepted when valid&ready
- dii_out_data  out  16  flit to debug ring
- dii_out_last  out  1  final flit of packet
- dii_out_valid  out  1  flit valid
- dii_out_ready  in  1  ring accepts flit
- dii_in_data  in  16  flit from debug ring
- dii_in_last  in  1  final flit of packet
- dii_in_valid  in  1  flit valid
- dii_in_ready  out  1  flit accepted
- glip_out_data  out  16  target-to-host word
- glip_out_valid  out  1  word valid
- glip_out_ready  in  1  host accepts word
- err_ingress  out  1  one-cycle pulse: ingress header length > MAX_PKT_LEN
- err_egress  out  1  one-cycle pulse: egress packet exceeded MAX_PKT_LEN

Behaviour:
- Transfer occurs on a rising clk edge with valid&ready. Valid must never depend on ready.
- Reset: all outputs 0 except glip_in_ready=1 and dii_in_ready=1. Both FSMs return to their first state and all counters clear. Reset mid-packet discards the partial packet with no flush. Buffer contents are don't-care.
- Ingress FSM, states I_HDR, I_PAY, I_DROP:
  - I_HDR: glip_in_ready=1, dii_out_valid=0. On accept, len=glip_in_data[CNT_W-1:0] with the upper bits checked.
    - len==0: stay in I_HDR, no flit.
    - full 16-bit value > MAX_PKT_LEN: rem=value (16-bit), pulse err_ingress, go to I_DROP.
    - otherwise: rem=len, go to I_PAY.
  - I_PAY: combinational pass-through, zero latency.
    - dii_out_valid=glip_in_valid, dii_out_data=glip_in_data, glip_in_ready=dii_out_ready, dii_out_last=(rem==1).
    - On transfer, rem decrements. When rem==1, go to I_HDR.
  - I_DROP: glip_in_ready=1, dii_out_valid=0. Each accepted word decrements rem; at rem==1 go to I_HDR.
- Egress FSM, states E_COLLECT, E_HDR, E_DATA. Buffer is MAX_PKT_LEN x 16 registers.
  - E_COLLECT: dii_in_ready=1.
    - Accepted flits are written to buf[wcnt] while wcnt<MAX_PKT_LEN, and wcnt increments (saturating at MAX_PKT_LEN).
    - An accepted flit with wcnt==MAX_PKT_LEN is dropped and err_egress pulses once per packet.
    - On an accepted flit with last=1, go to E_HDR with final count n = min(packet length, MAX_PKT_LEN).
  - E_HDR: dii_in_ready=0, glip_out_valid=1, glip_out_data=zero-extended n. On glip_out_ready, rcnt=0 and go to E_DATA.
  - E_DATA: glip_out_valid=1, glip_out_data=buf[rcnt]. On ready, rcnt increments; if rcnt==n-1, clear wcnt and go to E_COLLECT.
  - First collected flit to header valid: 1 cycle after the last-flit transfer.
  - No overlap: next packet collection starts the cycle after the final data word transfers.
- The ingress and egress paths are fully independent. Simultaneous activity on both is legal.
- Error pulses are registered, asserted the cycle after the triggering transfer.

Test Plan:
- Ingress basic: GLIP words 0x0003, 0xA001, 0xA002, 0xA003 with dii_out_ready=1 -> three flits A001/A002/A003, last only on A003, FSM back in I_HDR.
- Ingress backpressure and zero length: 0x0000 then 0x0002, 0xB001, 0xB002, with dii_out_ready toggled 1/0 each cycle -> header 0 yields no flit; glip_in_ready mirrors dii_out_ready in I_PAY; exactly 2 flits, last on B002.
- Ingress oversize: 0x000D followed by 13 words -> err_ingress pulses once; all 13 consumed; no dii_out_valid; the next 0x0001, 0xC0DE yields one flit with last=1.
- Egress basic: DII flits 0x1111, 0x2222(last) with glip_out_ready=1 -> GLIP 0x0002, 0x1111, 0x2222; dii_in_ready=0 from header until the final word transfers.
- Egress overflow: 14-flit DII packet -> err_egress single pulse; GLIP emits 0x000C plus the first 12 flits.
- Reset mid-operation: assert rst during I_PAY (rem=2) and E_DATA (rcnt=1) -> outputs at reset values immediately. After release, a fresh 0x0001, 0x5555 gives one flit with last=1.
